snap_ctrl_capture: RTL and testbench
====================================

Name: snap_ctrl_capture

Overview:
- User-clock-domain snapshot capture controller fed by the 32-bit software control word from an OPB ppc2simulink register (`user_data_out`).
- Decodes arm, trigger-select and write-enable-select bits from that word.
- Waits for a trigger, then writes a fixed-length burst of samples into a simple-dual-port BRAM write port.
- Returns a 32-bit status word (done flag and sample count) for a simulink2ppc register readable by software.

Parameters:
- DATA_W, 32, sample and BRAM data width.
- ADDR_W, 10, BRAM address width; capture length is 2^ADDR_W samples.
- OFF_W, 16, width of the post-trigger offset counter (used only with SNAP_OFFSET_EN).

Ports:
- user_clk  in  1  capture clock; all logic on its rising edge.
- user_rst  in  1  synchronous, active-high reset.
- ctrl  in  32  software control word from the ppc2simulink register, already in user_clk domain, quasi-static.
  - bit0 arm: rising edge starts a capture.
  - bit1 trig_sel: 1 = trigger immediately; 0 = use din_trig.
  - bit2 we_sel: 1 = write every cycle; 0 = write only on din_valid.
- din  in  DATA_W  sample data.
- din_valid  in  1  sample qualifier.
- din_trig  in  1  external trigger, level-sensitive, sampled only in ARMED.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_din  out  DATA_W  BRAM write data.
- bram_we  out  1  BRAM write strobe.
- status  out  32  bit31 = done, bit30 = armed/busy, bits[ADDR_W:0] = samples written, other bits 0.
- off_val  in  OFF_W  post-trigger offset in qualified samples (present only with SNAP_OFFSET_EN).

Behaviour:
- Reset values: bram_addr = 0, bram_din = 0, bram_we = 0, status = 0, state = IDLE, registered ctrl bit0 = 0.
- Arm edge:
  - arm_q registers ctrl bit0; arm_edge = bit0 & ~arm_q.
  - A level held high through reset release produces one edge on the first post-reset cycle.
- qual = we_sel ? 1 : din_valid.
- trig = trig_sel ? 1 : din_trig.
- States:
  - IDLE: bram_we = 0. On arm_edge → ARMED; clear count and done; set busy.
  - ARMED: if trig & qual → CAPTURE, and this sample is written at address 0. If trig & ~qual → CAPTURE with no write that cycle.
  - CAPTURE: each cycle with qual, write sample at the current count, then count+1. When the write at address 2^ADDR_W−1 is issued → DONE.
  - DONE: done = 1, busy = 0, count = 2^ADDR_W (saturated). No further writes.
- arm_edge in any state, including ARMED, CAPTURE and DONE, has top priority:
  - Goes to ARMED with count = 0, done = 0.
  - Any trigger or qual in that same cycle is ignored.
  - No write is issued that cycle.
- Write pipeline latency is 1 cycle: din and the write condition sampled at cycle t appear on bram_din, bram_addr and bram_we at t+1.
- bram_addr equals the count value at write time. Addresses never wrap within a capture.
- The status word updates in the same cycle as the corresponding bram_we.
- status count width is ADDR_W+1 bits, so the full count is representable.
- user_rst in any state returns to IDLE next edge; any in-flight write is dropped (bram_we = 0).
- ctrl bits 1 and 2 may change at any time and take effect combinationally on the next edge. Software must not change them mid-capture; the result is defined but unspecified in content.

Optional Feature:
- SNAP_OFFSET_EN defined:
  - Adds state DELAY between ARMED and CAPTURE, plus the off_val port.
  - On trigger, load off_val into the offset counter. If it is 0, go directly to CAPTURE exactly as in base behaviour.
  - Otherwise decrement on each qual cycle in DELAY, with no writes. The qual sample that takes the counter to 0 is not written; the next qual sample is address 0.
  - arm_edge and reset behave as in other states.
- SNAP_OFFSET_EN undefined: no DELAY state, no off_val port, no offset counter logic.

Decomposition:
- Package snap_pkg holds:
  - state enum {IDLE, ARMED, DELAY, CAPTURE, DONE};
  - ctrl bit index constants (CTRL_ARM = 0, CTRL_TRIG_SEL = 1, CTRL_WE_SEL = 2);
  - status bit constants (STAT_DONE = 31, STAT_BUSY = 30).
- One natural sub-module: snap_edge_det (1-bit registered rising-edge detector with sync reset), reused for arm.

Test Plan:
1. Reset, ctrl = 0x6 (imm trig, we always), then ctrl = 0x7 → 1024 writes, addr 0..1023 consecutive, din ramp matches; status = 0x8000_0400 after the last write.
2. ctrl = 0x1, din_valid toggling 1010…, din_trig pulsed at cycle 20 coinciding with valid → first write addr 0 = din at cycle 20; only valid samples written; done after 1024 valid samples.
3. Mid-capture re-arm (bit0 1→0→1 at count 300) → count resets to 0; no write in the edge cycle; status bit30 = 1, bit31 = 0.
4. user_rst asserted at count 500 for 1 cycle → next cycle bram_we = 0, status = 0, IDLE; no capture without a new arm edge.
5. Arm edge and trigger in the same cycle (ctrl 0x2→0x3) → no write that cycle; capture starts the following cycle at addr 0.
6. With SNAP_OFFSET_EN, off_val = 5, we_sel = 1 → first write is the 6th sample after trigger; off_val = 0 matches base timing.

Source files
------------

// File: rtl/snap_pkg.sv
// Shared types and constants for the snapshot capture controller:
// FSM state encoding, control-word bit positions and status-word bit positions.
package snap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        CAPTURE,
        DONE
    } state_t;

    // Control word bit positions (software -> fabric)
    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SEL = 1;
    localparam int CTRL_WE_SEL   = 2;

    // Status word bit positions (fabric -> software)
    localparam int STAT_DONE = 31;
    localparam int STAT_BUSY = 30;

endpackage

// File: rtl/snap_edge_det.sv
// 1-bit registered rising-edge detector with synchronous active-high reset.
// Ports: clk, rst (sync, active high), d (level in), rise (d & ~d_registered).
module snap_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    // q is cleared by reset, so a level held high through reset release
    // yields exactly one edge on the first post-reset cycle.
    assign rise = d & ~q;

endmodule

// File: rtl/snap_ctrl_capture.sv
// Snapshot capture controller: decodes arm/trigger/write-select bits from the
// software control word, waits for a trigger and writes 2^ADDR_W samples into
// a BRAM write port, reporting done/busy and sample count in a status word.
// Ports: user_clk, user_rst (sync, active high), ctrl[31:0], din, din_valid,
//        din_trig -> bram_addr, bram_din, bram_we, status[31:0];
//        off_val (post-trigger offset) only when SNAP_OFFSET_EN is defined.
// Build option: define SNAP_OFFSET_EN to add the post-trigger DELAY state.
module snap_ctrl_capture
    import snap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int OFF_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_trig,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic [31:0]       status
`ifdef SNAP_OFFSET_EN
    ,
    input  logic [OFF_W-1:0]  off_val
`endif
);

    // Status layout needs bits [ADDR_W:0] clear of the flag bits.
    if (ADDR_W < 1 || ADDR_W > 29 || OFF_W < 1) begin : g_param_chk
        $error("snap_ctrl_capture: unsupported parameter values");
    end

    state_t          state;
    state_t          state_nxt;
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] cnt_nxt;
    logic            done;
    logic            done_nxt;
    logic            busy;
    logic            busy_nxt;
    logic            wr;
    logic            arm_edge;
    logic            qual;
    logic            trig;
    logic            last;
    logic            ctrl_unused;

`ifdef SNAP_OFFSET_EN
    logic [OFF_W-1:0] off_cnt;
    logic [OFF_W-1:0] off_nxt;
`endif

    assign ctrl_unused = ^ctrl[31:3];

    snap_edge_det u_arm_edge (
        .clk  (user_clk),
        .rst  (user_rst),
        .d    (ctrl[CTRL_ARM]),
        .rise (arm_edge)
    );

    assign qual = ctrl[CTRL_WE_SEL] | din_valid;
    assign trig = ctrl[CTRL_TRIG_SEL] | din_trig;
    assign last = (cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
`ifdef SNAP_OFFSET_EN
            off_cnt   <= '0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            bram_we <= wr;
            if (wr) begin
                bram_addr <= cnt[ADDR_W-1:0];
                bram_din  <= din;
            end
`ifdef SNAP_OFFSET_EN
            off_cnt <= off_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = done;
        busy_nxt  = busy;
        wr        = 1'b0;
`ifdef SNAP_OFFSET_EN
        off_nxt   = off_cnt;
`endif
        if (arm_edge) begin
            // Re-arm wins over anything else happening this cycle.
            state_nxt = ARMED;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
            busy_nxt  = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                ARMED: begin
                    if (trig) begin
`ifdef SNAP_OFFSET_EN
                        if (off_val != '0) begin
                            off_nxt   = off_val;
                            state_nxt = DELAY;
                        end else begin
                            state_nxt = CAPTURE;
                            wr        = qual;
                        end
`else
                        state_nxt = CAPTURE;
                        wr        = qual;
`endif
                    end
                end
`ifdef SNAP_OFFSET_EN
                DELAY: begin
                    // The sample that drains the counter is discarded.
                    if (qual) begin
                        off_nxt = off_cnt - 1'b1;
                        if (off_cnt == OFF_W'(1)) begin
                            state_nxt = CAPTURE;
                        end
                    end
                end
`endif
                CAPTURE: begin
                    wr = qual;
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
            if (wr) begin
                cnt_nxt = cnt + 1'b1;
                if (last) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
        end
    end

    // Derived from registers updated on the same edge as bram_we.
    always_comb begin
        status             = '0;
        status[STAT_DONE]  = done;
        status[STAT_BUSY]  = busy;
        status[ADDR_W:0]   = cnt;
    end

endmodule

// File: tb/tb_snap_ctrl_capture.sv
// Directed self-checking bench for snap_ctrl_capture.
// Offset checks run only when SNAP_OFFSET_EN is defined.
module tb_snap_ctrl_capture;

    logic        user_clk;
    logic        user_rst;
    logic [31:0] ctrl;
    logic [31:0] din;
    logic        din_valid;
    logic        din_trig;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic        bram_we;
    logic [31:0] status;
`ifdef SNAP_OFFSET_EN
    logic [15:0] off_val;
`endif

    int checks;
    int failures;

    snap_ctrl_capture dut (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .ctrl      (ctrl),
        .din       (din),
        .din_valid (din_valid),
        .din_trig  (din_trig),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .status    (status)
`ifdef SNAP_OFFSET_EN
        ,
        .off_val   (off_val)
`endif
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    initial begin
        int nbad;
        int nwr;
        int ea;
        logic ew;
        checks    = 0;
        failures  = 0;
        user_rst  = 1'b1;
        ctrl      = 32'h6;
        din       = '0;
        din_valid = 1'b0;
        din_trig  = 1'b0;
`ifdef SNAP_OFFSET_EN
        off_val   = '0;
`endif
        // Reset state
        tick(); tick(); tick();
        chk("rst_we", {31'd0, bram_we}, 32'd0);
        chk("rst_status", status, 32'h0);
        chk("rst_addr", {22'd0, bram_addr}, 32'd0);
        chk("rst_din", bram_din, 32'd0);
        user_rst = 1'b0;
        tick();
        chk("idle_status", status, 32'h0);

        // 1: immediate trigger, write every cycle
        ctrl = 32'h7;
        tick();
        chk("t1_arm_we", {31'd0, bram_we}, 32'd0);
        chk("t1_arm_status", status, 32'h4000_0000);
        nbad = 0;
        for (int i = 0; i < 1024; i++) begin
            din = 32'hA000_0000 + i;
            tick();
            if (bram_we !== 1'b1 || bram_addr !== i[9:0] ||
                bram_din !== 32'hA000_0000 + i)
                nbad++;
        end
        chk("t1_bad_writes", nbad, 0);
        chk("t1_last_addr", {22'd0, bram_addr}, 32'd1023);
        chk("t1_done_status", status, 32'h8000_0400);
        tick();
        chk("t1_no_write_after", {31'd0, bram_we}, 32'd0);
        chk("t1_status_hold", status, 32'h8000_0400);

        // 2: external trigger, valid-qualified writes
        ctrl = 32'h0;
        tick();
        chk("t2_fall_no_arm", status, 32'h8000_0400);
        ctrl = 32'h1;
        tick();
        chk("t2_arm_status", status, 32'h4000_0000);
        nbad = 0;
        nwr  = 0;
        for (int c = 0; c < 2076; c++) begin
            din       = 32'hB000_0000 + c;
            din_valid = (c % 2 == 0);
            din_trig  = (c == 20);
            tick();
            ew = (c >= 20) && (c <= 2066) && (c % 2 == 0);
            ea = (c - 20) / 2;
            if (bram_we) nwr++;
            if (bram_we !== ew)
                nbad++;
            else if (ew && (bram_addr !== ea[9:0] ||
                            bram_din !== 32'hB000_0000 + c))
                nbad++;
        end
        din_trig = 1'b0;
        chk("t2_bad_cycles", nbad, 0);
        chk("t2_write_count", nwr, 1024);
        chk("t2_done_status", status, 32'h8000_0400);

        // 3: re-arm mid-capture at count 300
        ctrl      = 32'h0;
        din_valid = 1'b0;
        tick();
        ctrl = 32'h7;
        tick();
        for (int i = 0; i < 300; i++) begin
            din = 32'hD000_0000 + i;
            tick();
        end
        chk("t3_count300", status, 32'h4000_012C);
        ctrl = 32'h6;
        din  = 32'hD000_012C;
        tick();
        chk("t3_low_still_writes", {22'd0, bram_addr}, 32'd300);
        chk("t3_low_status", status, 32'h4000_012D);
        ctrl = 32'h7;
        din  = 32'hDEAD_0000;
        tick();
        chk("t3_rearm_no_we", {31'd0, bram_we}, 32'd0);
        chk("t3_rearm_status", status, 32'h4000_0000);
        din = 32'hD000_0ABC;
        tick();
        chk("t3_restart_we", {31'd0, bram_we}, 32'd1);
        chk("t3_restart_addr", {22'd0, bram_addr}, 32'd0);
        chk("t3_restart_din", bram_din, 32'hD000_0ABC);
        chk("t3_restart_status", status, 32'h4000_0001);

        // 4: reset at count 500, no capture without a new edge
        for (int i = 1; i < 500; i++) begin
            din = 32'hD100_0000 + i;
            tick();
        end
        chk("t4_count500", status, 32'h4000_01F4);
        user_rst = 1'b1;
        ctrl     = 32'h6;
        tick();
        chk("t4_rst_we", {31'd0, bram_we}, 32'd0);
        chk("t4_rst_status", status, 32'h0);
        user_rst = 1'b0;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bram_we) nwr++;
        end
        chk("t4_idle_writes", nwr, 0);
        chk("t4_idle_status", status, 32'h0);

        // 5: arm edge and trigger in the same cycle
        ctrl      = 32'h2;
        din_valid = 1'b1;
        tick();
        chk("t5_pre_status", status, 32'h0);
        ctrl = 32'h3;
        din  = 32'hE000_0000;
        tick();
        chk("t5_edge_no_we", {31'd0, bram_we}, 32'd0);
        chk("t5_edge_status", status, 32'h4000_0000);
        din = 32'hE000_0001;
        tick();
        chk("t5_first_we", {31'd0, bram_we}, 32'd1);
        chk("t5_first_addr", {22'd0, bram_addr}, 32'd0);
        chk("t5_first_din", bram_din, 32'hE000_0001);
        chk("t5_first_status", status, 32'h4000_0001);

        // Arm level held through reset release arms once
        user_rst = 1'b1;
        ctrl     = 32'h7;
        tick(); tick();
        chk("lvl_rst_status", status, 32'h0);
        user_rst = 1'b0;
        tick();
        chk("lvl_arm_we", {31'd0, bram_we}, 32'd0);
        chk("lvl_arm_status", status, 32'h4000_0000);
        din = 32'hF000_0001;
        tick();
        chk("lvl_first_we", {31'd0, bram_we}, 32'd1);
        chk("lvl_first_din", bram_din, 32'hF000_0001);

        // Trigger without qual: enter capture without a write
        ctrl = 32'h0;
        tick();
        ctrl      = 32'h1;
        din_valid = 1'b0;
        din_trig  = 1'b1;
        tick();
        chk("nq_edge_we", {31'd0, bram_we}, 32'd0);
        tick();
        chk("nq_trig_we", {31'd0, bram_we}, 32'd0);
        chk("nq_trig_status", status, 32'h4000_0000);
        din_trig  = 1'b0;
        din_valid = 1'b1;
        din       = 32'h0000_0055;
        tick();
        chk("nq_first_we", {31'd0, bram_we}, 32'd1);
        chk("nq_first_addr", {22'd0, bram_addr}, 32'd0);
        chk("nq_first_din", bram_din, 32'h0000_0055);
        chk("nq_first_status", status, 32'h4000_0001);
        din_valid = 1'b0;
        tick();
        chk("nq_idle_we", {31'd0, bram_we}, 32'd0);

`ifdef SNAP_OFFSET_EN
        // 6: post-trigger offset
        off_val = 16'd5;
        ctrl    = 32'h0;
        tick();
        ctrl = 32'h7;
        tick();
        din = 32'hC000_0000;
        tick();
        chk("t6_trig_no_we", {31'd0, bram_we}, 32'd0);
        nwr = 0;
        for (int k = 1; k <= 5; k++) begin
            din = 32'hC000_0000 + k;
            tick();
            if (bram_we) nwr++;
        end
        chk("t6_delay_writes", nwr, 0);
        din = 32'hC000_0006;
        tick();
        chk("t6_first_we", {31'd0, bram_we}, 32'd1);
        chk("t6_first_addr", {22'd0, bram_addr}, 32'd0);
        chk("t6_first_din", bram_din, 32'hC000_0006);
        off_val = 16'd0;
        ctrl    = 32'h6;
        tick();
        ctrl = 32'h7;
        tick();
        din = 32'hC000_0007;
        tick();
        chk("t6_zero_we", {31'd0, bram_we}, 32'd1);
        chk("t6_zero_addr", {22'd0, bram_addr}, 32'd0);
        chk("t6_zero_din", bram_din, 32'hC000_0007);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
